// File: rtl/otdr_shot_sequencer_if.sv
// OTDR shot sequencer bus: command/config inputs and registered status.
// master = controller side, slave = sequencer side (ext_trig only with OTDR_EXT_TRIG_EN).
interface otdr_shot_sequencer_if #(
   parameter int WIDTH_W  = 8,
   parameter int PERIOD_W = 16,
   parameter int SHOT_W   = 16
);
   logic                start;
   logic                abort;
   logic [WIDTH_W-1:0]  pulse_width;
   logic [PERIOD_W-1:0] pulse_period;
   logic [PERIOD_W-1:0] acq_len;
   logic [SHOT_W-1:0]   num_shots;
   logic                pulse_out;
   logic                acq_valid;
   logic [PERIOD_W-1:0] sample_idx;
   logic [SHOT_W-1:0]   shot_idx;
   logic                busy;
   logic                done;
   logic                aborted;
   logic                cfg_err;
`ifdef OTDR_EXT_TRIG_EN
   logic                ext_trig;
`endif

   modport master (
      output start, abort, pulse_width, pulse_period,
      output acq_len, num_shots,
`ifdef OTDR_EXT_TRIG_EN
      output ext_trig,
`endif
      input  pulse_out, acq_valid, sample_idx, shot_idx,
      input  busy, done, aborted, cfg_err
   );

   modport slave (
      input  start, abort, pulse_width, pulse_period,
      input  acq_len, num_shots,
`ifdef OTDR_EXT_TRIG_EN
      input  ext_trig,
`endif
      output pulse_out, acq_valid, sample_idx, shot_idx,
      output busy, done, aborted, cfg_err
   );
endinterface

// File: rtl/otdr_shot_sequencer.sv
// OTDR shot sequencer: fires a burst of laser pulses, opens acquisition windows.
// Ports: clock, reset_async (async, active-high), bus (slave). Option: OTDR_EXT_TRIG_EN.
module otdr_shot_sequencer #(
   parameter int WIDTH_W  = 8,
   parameter int PERIOD_W = 16,
   parameter int SHOT_W   = 16
) (
   input  logic clock,
   input  logic reset_async,
   otdr_shot_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, CHECK, SHOT, DONE
`ifdef OTDR_EXT_TRIG_EN
      , WAIT_TRIG
`endif
   } state_t;

   localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0] P_TWO = PERIOD_W'(2);
   localparam logic [SHOT_W-1:0]   S_ONE = SHOT_W'(1);

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] p_q, p_d;
   logic [SHOT_W-1:0]   shot_q, shot_d;
   logic [PERIOD_W-1:0] width_q, width_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] len_q, len_d;
   logic [SHOT_W-1:0]   nshots_q, nshots_d;
   logic                pulse_q, pulse_d;
   logic                acqv_q, acqv_d;
   logic [PERIOD_W-1:0] sidx_q, sidx_d;
   logic [SHOT_W-1:0]   shot_o_q, shot_o_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                abrt_q, abrt_d;
   logic                err_q, err_d;

   logic [PERIOD_W-1:0] w_in;
   logic                cfg_bad;
   state_t              run_st;

`ifdef OTDR_EXT_TRIG_EN
   logic [2:0] sync_q, sync_d;
   logic       trig_edge;

   // [1:0] is the synchronizer, [2] the previous sample for edge detect
   assign sync_d    = {sync_q[1:0], bus.ext_trig};
   assign trig_edge = sync_q[1] & ~sync_q[2];
   assign run_st    = WAIT_TRIG;
`else
   assign run_st    = SHOT;
`endif

   assign w_in    = PERIOD_W'(bus.pulse_width);
   assign cfg_bad = (w_in == '0) || (bus.num_shots == '0)
                 || (w_in >= bus.pulse_period)
                 || (bus.acq_len > bus.pulse_period)
                 || (bus.pulse_period < P_TWO);

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      shot_d   = shot_q;
      width_d  = width_q;
      period_d = period_q;
      len_d    = len_q;
      nshots_d = nshots_q;
      pulse_d  = 1'b0;
      acqv_d   = 1'b0;
      sidx_d   = '0;
      shot_o_d = shot_o_q;
      done_d   = 1'b0;
      abrt_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) state_d = CHECK;
         end
         CHECK: begin
            width_d  = w_in;
            period_d = bus.pulse_period;
            len_d    = bus.acq_len;
            nshots_d = bus.num_shots;
            p_d      = '0;
            shot_d   = '0;
            shot_o_d = '0;
            if (bus.abort) begin
               abrt_d  = 1'b1;
               state_d = IDLE;
            end else if (cfg_bad) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = run_st;
            end
         end
         SHOT: begin
            if (bus.abort) begin
               abrt_d  = 1'b1;
               state_d = IDLE;
            end else begin
               // outputs trail p by one edge, shot_idx aligned with them
               pulse_d  = p_q < width_q;
               acqv_d   = p_q < len_q;
               sidx_d   = (p_q < len_q) ? p_q : '0;
               shot_o_d = shot_q;
               if (p_q == period_q - P_ONE) begin
                  if (shot_q < nshots_q - S_ONE) begin
                     shot_d  = shot_q + S_ONE;
                     p_d     = '0;
                     state_d = run_st;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  p_d = p_q + P_ONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
`ifdef OTDR_EXT_TRIG_EN
         WAIT_TRIG: begin
            if (bus.abort) begin
               abrt_d  = 1'b1;
               state_d = IDLE;
            end else if (trig_edge) begin
               state_d = SHOT;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   always_ff @(posedge clock or posedge reset_async) begin
      if (reset_async) begin
         state_q  <= IDLE;
         p_q      <= '0;
         shot_q   <= '0;
         width_q  <= '0;
         period_q <= '0;
         len_q    <= '0;
         nshots_q <= '0;
         pulse_q  <= 1'b0;
         acqv_q   <= 1'b0;
         sidx_q   <= '0;
         shot_o_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abrt_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef OTDR_EXT_TRIG_EN
         sync_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         shot_q   <= shot_d;
         width_q  <= width_d;
         period_q <= period_d;
         len_q    <= len_d;
         nshots_q <= nshots_d;
         pulse_q  <= pulse_d;
         acqv_q   <= acqv_d;
         sidx_q   <= sidx_d;
         shot_o_q <= shot_o_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abrt_q   <= abrt_d;
         err_q    <= err_d;
`ifdef OTDR_EXT_TRIG_EN
         sync_q   <= sync_d;
`endif
      end
   end

   assign bus.pulse_out  = pulse_q;
   assign bus.acq_valid  = acqv_q;
   assign bus.sample_idx = sidx_q;
   assign bus.shot_idx   = shot_o_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.aborted    = abrt_q;
   assign bus.cfg_err    = err_q;
endmodule
